// File: rtl/skip_counter_pkg.sv
// Shared constants and types for the skip_counter family of jump-sequence counters.
package skip_counter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_LOW     = 5;
    localparam int DEF_HIGH    = 14;
    localparam int DEF_RST_VAL = 0;
    localparam int DEF_WRAP_W  = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/skip_counter_next.sv
// Combinational next-state of a LOW..HIGH jump counter: steps modulo 2^WIDTH,
// jumping across the range only when sitting exactly on the bound in the count direction.
module skip_counter_next
    import skip_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOW   = DEF_LOW,
    parameter int HIGH  = DEF_HIGH
) (
    input  logic [WIDTH-1:0] val,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_hit
);

    localparam logic [WIDTH-1:0] LOW_V  = WIDTH'(LOW);
    localparam logic [WIDTH-1:0] HIGH_V = WIDTH'(HIGH);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    dir_e dir;
    assign dir = dir_e'(up);

    // Out-of-range values just keep stepping (with plain modulo rollover) until they hit a bound.
    always_comb begin
        nxt      = val;
        wrap_hit = 1'b0;
        unique case (dir)
            DIR_UP: begin
                if (val == HIGH_V) begin
                    nxt      = LOW_V;
                    wrap_hit = 1'b1;
                end else begin
                    nxt = val + ONE;
                end
            end
            DIR_DOWN: begin
                if (val == LOW_V) begin
                    nxt      = HIGH_V;
                    wrap_hit = 1'b1;
                end else begin
                    nxt = val - ONE;
                end
            end
            default: nxt = val;
        endcase
    end

endmodule

// File: rtl/skip_counter.sv
// Cyclic up/down counter over LOW..HIGH with synchronous load, one-cycle wrap flag
// and a saturating wrap tally; next-state and D-select are exported for logging.
module skip_counter
    import skip_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LOW     = DEF_LOW,
    parameter int HIGH    = DEF_HIGH,
    parameter int RST_VAL = DEF_RST_VAL,
    parameter int WRAP_W  = DEF_WRAP_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic              LOAD,
    input  logic              UP,
    input  logic [WIDTH-1:0]  IN,
    output logic [WIDTH-1:0]  VAL,
    output logic [WIDTH-1:0]  LOG_LOGIC,
    output logic [WIDTH-1:0]  LOG_SWITCHING,
    output logic              TC,
    output logic [WRAP_W-1:0] WRAPS
);

    if (WIDTH < 2 || !(LOW < HIGH) || LOW < 0 || HIGH > (2**WIDTH - 1)) begin : g_bad_params
        $error("skip_counter: need WIDTH>=2 and 0 <= LOW < HIGH <= 2^WIDTH-1");
    end

    localparam logic [WIDTH-1:0]  RST_V    = WIDTH'(RST_VAL);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  val_q, val_d;
    logic              tc_q, tc_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [WIDTH-1:0]  nxt;
    logic              wrap_hit;
    logic              wrap_evt;

    skip_counter_next #(
        .WIDTH (WIDTH),
        .LOW   (LOW),
        .HIGH  (HIGH)
    ) u_next (
        .val      (val_q),
        .up       (UP),
        .nxt      (nxt),
        .wrap_hit (wrap_hit)
    );

    // Only a bound jump on an enabled, non-load cycle counts; modulo rollover does not.
    assign wrap_evt = CE && !LOAD && wrap_hit;

    always_comb begin
        val_d   = val_q;
        tc_d    = 1'b0;
        wraps_d = wraps_q;
        if (LOAD) begin
            val_d   = IN;
            wraps_d = '0;
        end else if (CE) begin
            val_d = nxt;
            tc_d  = wrap_evt;
            if (wrap_evt && wraps_q != WRAP_MAX) begin
                wraps_d = wraps_q + WRAP_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            val_q   <= RST_V;
            tc_q    <= 1'b0;
            wraps_q <= '0;
        end else begin
            val_q   <= val_d;
            tc_q    <= tc_d;
            wraps_q <= wraps_d;
        end
    end

    assign VAL           = val_q;
    assign TC            = tc_q;
    assign WRAPS         = wraps_q;
    assign LOG_LOGIC     = nxt;
    assign LOG_SWITCHING = val_d;

endmodule

// File: tb/tb_skip_counter.sv
// Self-checking bench for skip_counter: directed scenarios plus random traffic against a
// behavioural model; a second instance with a 2-bit tally exercises saturation.
module tb_skip_counter;

    localparam int LO = 5;
    localparam int HI = 14;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CE = 1'b0, LOAD = 1'b0, UP = 1'b0;
    logic [3:0] IN = '0;
    logic [3:0] VAL, LOG_LOGIC, LOG_SWITCHING, WRAPS;
    logic       TC;
    logic [3:0] s_val, s_logic, s_sw;
    logic       s_tc;
    logic [1:0] s_wraps;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: value, last-cycle wrap flag, unsaturated wrap count.
    int m_val = 0;
    int m_tc  = 0;
    int m_cnt = 0;

    always #5 CLK = ~CLK;

    skip_counter u_dut (
        .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .UP(UP), .IN(IN),
        .VAL(VAL), .LOG_LOGIC(LOG_LOGIC), .LOG_SWITCHING(LOG_SWITCHING),
        .TC(TC), .WRAPS(WRAPS)
    );

    skip_counter #(.WRAP_W(2)) u_sat (
        .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .UP(UP), .IN(IN),
        .VAL(s_val), .LOG_LOGIC(s_logic), .LOG_SWITCHING(s_sw),
        .TC(s_tc), .WRAPS(s_wraps)
    );

    function automatic int mnext(int v, bit up);
        if (up) return (v == HI) ? LO : (v + 1) % 16;
        else    return (v == LO) ? HI : (v + 15) % 16;
    endfunction

    function automatic int sat(int c, int mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic drive(bit ce, bit load, bit up, int in);
        CE = ce; LOAD = load; UP = up; IN = 4'(in);
    endtask

    task automatic model_reset();
        m_val = 0; m_tc = 0; m_cnt = 0;
    endtask

    // Advance one clock with the currently driven inputs; leaves time at posedge+1.
    task automatic tick();
        bit wr;
        int nv;
        wr = CE && !LOAD && ((UP && m_val == HI) || (!UP && m_val == LO));
        nv = LOAD ? int'(IN) : (CE ? mnext(m_val, UP) : m_val);
        @(posedge CLK);
        #1;
        m_val = nv;
        m_tc  = wr;
        m_cnt = LOAD ? 0 : m_cnt + int'(wr);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            n_checks++;
            if (VAL !== 4'd0 || TC !== 1'b0 || WRAPS !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_hold: VAL=%0d TC=%0d WRAPS=%0d, want 0/0/0", VAL, TC, WRAPS);
            end
        end
        model_reset();
        RST = 1'b1;
        tick();
        n_checks++;
        if (VAL !== 4'd15) begin
            n_fail++;
            $display("FAIL reset_release: VAL=%0d want 15", VAL);
        end
    endtask

    task automatic test_legacy_down();
        int exp_seq[6] = '{7, 6, 5, 14, 13, 12};
        drive(0, 1, 0, 8);
        tick();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (VAL !== 4'(exp_seq[i]) || VAL !== 4'(m_val)) begin
                n_fail++;
                $display("FAIL legacy_val[%0d]: VAL=%0d want %0d", i, VAL, exp_seq[i]);
            end
            n_checks++;
            if (TC !== (i == 3)) begin
                n_fail++;
                $display("FAIL legacy_tc[%0d]: TC=%0d want %0d", i, TC, i == 3);
            end
        end
        n_checks++;
        if (WRAPS !== 4'd1) begin
            n_fail++;
            $display("FAIL legacy_wraps: WRAPS=%0d want 1", WRAPS);
        end
    endtask

    task automatic test_up_wrap();
        drive(0, 1, 1, 13);
        tick();
        drive(1, 0, 1, 0);
        tick();
        n_checks++;
        if (VAL !== 4'd14 || LOG_LOGIC !== 4'd5) begin
            n_fail++;
            $display("FAIL up_at_high: VAL=%0d LOG_LOGIC=%0d want 14/5", VAL, LOG_LOGIC);
        end
        tick();
        n_checks++;
        if (VAL !== 4'd5 || TC !== 1'b1) begin
            n_fail++;
            $display("FAIL up_wrap: VAL=%0d TC=%0d want 5/1", VAL, TC);
        end
        tick();
        n_checks++;
        if (VAL !== 4'd6 || TC !== 1'b0) begin
            n_fail++;
            $display("FAIL up_after: VAL=%0d TC=%0d want 6/0", VAL, TC);
        end
    endtask

    task automatic test_priority_hold();
        drive(0, 1, 0, 9);
        tick();
        drive(1, 1, 0, 3);
        tick();
        n_checks++;
        if (VAL !== 4'd3 || WRAPS !== 4'd0 || TC !== 1'b0) begin
            n_fail++;
            $display("FAIL load_priority: VAL=%0d WRAPS=%0d TC=%0d want 3/0/0", VAL, WRAPS, TC);
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (LOG_SWITCHING !== 4'd3 || LOG_LOGIC !== 4'd2) begin
                n_fail++;
                $display("FAIL hold_comb[%0d]: LOG_SWITCHING=%0d LOG_LOGIC=%0d want 3/2", i, LOG_SWITCHING, LOG_LOGIC);
            end
            tick();
            n_checks++;
            if (VAL !== 4'd3) begin
                n_fail++;
                $display("FAIL hold_val[%0d]: VAL=%0d want 3", i, VAL);
            end
        end
    endtask

    task automatic test_saturation();
        drive(0, 1, 0, 14);
        tick();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 45; i++) begin
            tick();
            n_checks++;
            if (s_tc !== 1'(m_tc) || TC !== 1'(m_tc) || s_wraps !== 2'(sat(m_cnt, 3))) begin
                n_fail++;
                $display("FAIL sat_step[%0d]: s_tc=%0d TC=%0d s_wraps=%0d want tc %0d wraps %0d",
                         i, s_tc, TC, s_wraps, m_tc, sat(m_cnt, 3));
            end
        end
        n_checks++;
        if (s_wraps !== 2'd3 || WRAPS !== 4'd4) begin
            n_fail++;
            $display("FAIL sat_final: s_wraps=%0d WRAPS=%0d want 3/4", s_wraps, WRAPS);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 0, 11);
        tick();
        drive(1, 0, 1, 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (VAL !== 4'd0 || TC !== 1'b0 || WRAPS !== 4'd0 || s_val !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: VAL=%0d TC=%0d WRAPS=%0d s_val=%0d want 0", VAL, TC, WRAPS, s_val);
        end
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            n_checks++;
            if (VAL !== 4'd0 || WRAPS !== 4'd0) begin
                n_fail++;
                $display("FAIL async_hold[%0d]: VAL=%0d WRAPS=%0d want 0/0", i, VAL, WRAPS);
            end
        end
        RST = 1'b1;
    endtask

    task automatic test_random();
        int lg, sw;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(11, 0) == 0,
                  $urandom_range(1, 0) == 1, $urandom_range(15, 0));
            #1;
            lg = mnext(m_val, UP);
            sw = LOAD ? int'(IN) : (CE ? lg : m_val);
            n_checks++;
            if (LOG_LOGIC !== 4'(lg) || LOG_SWITCHING !== 4'(sw)) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: LOG_LOGIC=%0d LOG_SWITCHING=%0d want %0d/%0d",
                         i, LOG_LOGIC, LOG_SWITCHING, lg, sw);
            end
            tick();
            n_checks++;
            if (VAL !== 4'(m_val) || TC !== 1'(m_tc) || WRAPS !== 4'(sat(m_cnt, 15))
                || s_wraps !== 2'(sat(m_cnt, 3))) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: VAL=%0d TC=%0d WRAPS=%0d s_wraps=%0d want %0d/%0d/%0d/%0d",
                         i, VAL, TC, WRAPS, s_wraps, m_val, m_tc, sat(m_cnt, 15), sat(m_cnt, 3));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_legacy_down();
        test_up_wrap();
        test_priority_hold();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
